// File: rtl/dac8563_pkg.sv
// dac8563_pkg: shared definitions for the DAC8563 command sequencer.
//   - DAC8563 command / address field codes and a frame builder
//   - the four initialisation frame words
//   - SPI master state codes seen on i_spi_state
//   - sequencer FSM state enum and frame index constants
package dac8563_pkg;

    // 3-bit command field, frame bits [21:19]
    localparam logic [2:0] CMD_WR_IN       = 3'b000;  // write input register
    localparam logic [2:0] CMD_WR_UPD_ALL  = 3'b010;  // write input reg, update all DACs
    localparam logic [2:0] CMD_RESET       = 3'b101;
    localparam logic [2:0] CMD_LDAC        = 3'b110;
    localparam logic [2:0] CMD_REF         = 3'b111;

    // 3-bit address field, frame bits [18:16]
    localparam logic [2:0] ADDR_A          = 3'b000;
    localparam logic [2:0] ADDR_B          = 3'b001;
    localparam logic [2:0] ADDR_GAIN       = 3'b010;

    function automatic logic [23:0] mk_frame(input logic [2:0]  cmd,
                                             input logic [2:0]  addr,
                                             input logic [15:0] data);
        return {2'b00, cmd, addr, data};
    endfunction

    // Initialisation frames, sent in index order 0..3
    localparam logic [23:0] INIT_SW_RESET  = 24'h280001;  // software reset
    localparam logic [23:0] INIT_REF_ON    = 24'h380001;  // internal reference on
    localparam logic [23:0] INIT_LDAC_OFF  = 24'h300003;  // LDAC pins inactive, both channels
    localparam logic [23:0] INIT_GAIN2     = 24'h020000;  // gain 2, both channels

    // Frame indices: 0-3 init, 4 channel A, 5 channel B
    localparam logic [2:0] IDX_LAST_INIT   = 3'd3;
    localparam logic [2:0] IDX_A           = 3'd4;
    localparam logic [2:0] IDX_B           = 3'd5;

    // SPI master state codes
    localparam logic [2:0] SPI_IDLE        = 3'd0;
    localparam logic [2:0] SPI_DONE        = 3'd4;

    typedef enum logic [2:0] {
        S_POR,
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_GAP
    } seq_state_e;

endpackage

// File: rtl/dac8563_frame_rom.sv
// dac8563_frame_rom: combinational frame lookup.
//   i_idx   frame index (0-3 init, 4 channel A, 5 channel B)
//   i_a     channel A shadow code
//   i_b     channel B shadow code
//   o_word  24-bit DAC8563 frame for that index (0 for unused indices)
module dac8563_frame_rom
    import dac8563_pkg::*;
(
    input  logic [2:0]  i_idx,
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [23:0] o_word
);

    always_comb begin
        o_word = '0;
        case (i_idx)
            3'd0:    o_word = INIT_SW_RESET;
            3'd1:    o_word = INIT_REF_ON;
            3'd2:    o_word = INIT_LDAC_OFF;
            3'd3:    o_word = INIT_GAIN2;
            IDX_A:   o_word = mk_frame(CMD_WR_IN, ADDR_A, i_a);
            // B also latches both DAC registers, so A and B move together here
            IDX_B:   o_word = mk_frame(CMD_WR_UPD_ALL, ADDR_B, i_b);
            default: o_word = '0;
        endcase
    end

endmodule

// File: rtl/dac8563_cmd_seq.sv
// dac8563_cmd_seq: command sequencer in front of the DAC8563 SPI master.
// Plays the four-frame init sequence after a power-on delay, then turns
// i_update requests into an A/B frame pair, one frame per SPI transaction.
//   i_clk, i_fRST      clock, asynchronous active-low reset
//   i_ch_a_data/_b     16-bit channel codes, captured on i_update
//   i_update           one-cycle request to write both channels
//   i_spi_state        SPI master state (0 idle .. 4 done)
//   o_spi_start        start strobe, held until the master leaves idle
//   o_mosi_data        24-bit frame, stable for the whole transaction
//   o_init_done        sticky, init sequence completed
//   o_busy             high in every state except IDLE
//   o_err              sticky handshake timeout
module dac8563_cmd_seq
    import dac8563_pkg::*;
#(
    parameter int POR_DELAY = 20000,
    parameter int GAP       = 10,
    parameter int TIMEOUT   = 4096
) (
    input  logic        i_clk,
    input  logic        i_fRST,
    input  logic [15:0] i_ch_a_data,
    input  logic [15:0] i_ch_b_data,
    input  logic        i_update,
    input  logic [2:0]  i_spi_state,
    output logic        o_spi_start,
    output logic [23:0] o_mosi_data,
    output logic        o_init_done,
    output logic        o_busy,
    output logic        o_err
);

    localparam int PW = $clog2(POR_DELAY + 1);
    localparam int GW = $clog2(GAP + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [PW-1:0] POR_LAST = PW'(POR_DELAY - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    seq_state_e    state_q, state_d;
    logic [PW-1:0] por_cnt_q, por_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [15:0]   sh_a_q, sh_a_d;
    logic [15:0]   sh_b_q, sh_b_d;
    logic          pend_q, pend_d;
    logic          dead_q, dead_d;      // init aborted: ignore updates until reset
    logic          start_q, start_d;
    logic [23:0]   mosi_q, mosi_d;
    logic          init_done_q, init_done_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic [23:0]   rom_word;
    logic          abort;

    dac8563_frame_rom u_rom (
        .i_idx  (idx_q),
        .i_a    (sh_a_q),
        .i_b    (sh_b_q),
        .o_word (rom_word)
    );

    always_comb begin
        state_d     = state_q;
        por_cnt_d   = por_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        to_cnt_d    = to_cnt_q;
        idx_d       = idx_q;
        sh_a_d      = sh_a_q;
        sh_b_d      = sh_b_q;
        pend_d      = pend_q;
        dead_d      = dead_q;
        start_d     = start_q;
        mosi_d      = mosi_q;
        init_done_d = init_done_q;
        err_d       = err_q;
        abort       = 1'b0;

        // Capture runs in every state; last request wins, no queueing.
        if (i_update) begin
            sh_a_d = i_ch_a_data;
            sh_b_d = i_ch_b_data;
            pend_d = 1'b1;
        end

        case (state_q)
            S_POR: begin
                if (por_cnt_q == POR_LAST) begin
                    state_d = S_LOAD;
                    idx_d   = 3'd0;
                end else begin
                    por_cnt_d = por_cnt_q + 1'b1;
                end
            end

            S_IDLE: begin
                // Look at i_update directly so a request in IDLE loads next cycle.
                if ((pend_q || i_update) && !dead_q) begin
                    state_d = S_LOAD;
                    idx_d   = IDX_A;
                end
            end

            S_LOAD: begin
                mosi_d  = rom_word;
                start_d = 1'b1;
                state_d = S_START;
                // A fresh request landing on this cycle stays pending.
                if (idx_q == IDX_A) pend_d = i_update;
            end

            S_START: begin
                to_cnt_d = '0;
                if (i_spi_state != SPI_IDLE) begin
                    start_d = 1'b0;
                    state_d = S_WAIT_DONE;
                end else begin
                    state_d = S_WAIT_ACK;
                end
            end

            S_WAIT_ACK: begin
                if (i_spi_state != SPI_IDLE) begin
                    start_d  = 1'b0;
                    state_d  = S_WAIT_DONE;
                    to_cnt_d = to_cnt_q + 1'b1;
                end else if (to_cnt_q == TO_LAST) begin
                    abort = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end

            S_WAIT_DONE: begin
                if (i_spi_state == SPI_DONE) begin
                    state_d   = S_GAP;
                    gap_cnt_d = '0;
                end else if (to_cnt_q == TO_LAST) begin
                    abort = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end

            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    if (idx_q < IDX_LAST_INIT) begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_LOAD;
                    end else if (idx_q == IDX_LAST_INIT) begin
                        init_done_d = 1'b1;
                        state_d     = S_IDLE;
                    end else if (idx_q == IDX_A) begin
                        idx_d   = IDX_B;
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Timeout drops the current frame (and the rest of its pair).
        if (abort) begin
            err_d   = 1'b1;
            start_d = 1'b0;
            state_d = S_IDLE;
            if (idx_q <= IDX_LAST_INIT) dead_d = 1'b1;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_fRST) begin
        if (!i_fRST) begin
            state_q     <= S_POR;
            por_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            to_cnt_q    <= '0;
            idx_q       <= '0;
            sh_a_q      <= '0;
            sh_b_q      <= '0;
            pend_q      <= 1'b0;
            dead_q      <= 1'b0;
            start_q     <= 1'b0;
            mosi_q      <= '0;
            init_done_q <= 1'b0;
            busy_q      <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            por_cnt_q   <= por_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            to_cnt_q    <= to_cnt_d;
            idx_q       <= idx_d;
            sh_a_q      <= sh_a_d;
            sh_b_q      <= sh_b_d;
            pend_q      <= pend_d;
            dead_q      <= dead_d;
            start_q     <= start_d;
            mosi_q      <= mosi_d;
            init_done_q <= init_done_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign o_spi_start = start_q;
    assign o_mosi_data = mosi_q;
    assign o_init_done = init_done_q;
    assign o_busy      = busy_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_dac8563_cmd_seq.sv
// Bench for dac8563_cmd_seq: behavioural SPI master model plus a frame
// scoreboard. Stimulus pushes the expected frames; the master model pops
// and compares each frame it accepts.
module tb_dac8563_cmd_seq;

    localparam int POR_DELAY = 300;
    localparam int GAP       = 10;
    localparam int TIMEOUT   = 200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] a_data, b_data;
    logic        upd;
    logic [2:0]  spi_st;
    logic        spi_start;
    logic [23:0] mosi;
    logic        init_done, busy, err;

    logic [23:0] exp_q[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          frames_seen = 0;
    int          strobe_viol = 0;
    bit          no_ack = 1'b0;

    dac8563_cmd_seq #(.POR_DELAY(POR_DELAY), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
        .i_clk       (clk),
        .i_fRST      (rst_n),
        .i_ch_a_data (a_data),
        .i_ch_b_data (b_data),
        .i_update    (upd),
        .i_spi_state (spi_st),
        .o_spi_start (spi_start),
        .o_mosi_data (mosi),
        .o_init_done (init_done),
        .o_busy      (busy),
        .o_err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // SPI master model and scoreboard monitor, evaluated on falling edges.
    initial begin
        int          cnt;
        int          cyc;
        int          last_done;
        bit          done_valid;
        bit          prev_start;
        logic [23:0] held;
        spi_st = 3'd0; cnt = 0; cyc = 0; last_done = 0; done_valid = 0;
        prev_start = 0; held = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                spi_st = 3'd0; cnt = 0; done_valid = 0; prev_start = 0;
                continue;
            end
            if (spi_start && spi_st == 3'd4) strobe_viol++;
            if (spi_start && !prev_start && done_valid && (cyc - last_done) < GAP + 2)
                strobe_viol++;
            prev_start = spi_start;
            case (spi_st)
                3'd0: if (spi_start && !no_ack) begin
                    spi_st = 3'd1; cnt = 0; held = mosi; frames_seen++;
                    if (exp_q.size() == 0) check("unexpected_frame", {8'h0, mosi}, 32'hFFFFFFFF);
                    else check("frame", {8'h0, mosi}, {8'h0, exp_q.pop_front()});
                end
                3'd1: if (++cnt == 2) begin spi_st = 3'd2; cnt = 0; end
                3'd2: if (++cnt == 8) begin spi_st = 3'd3; cnt = 0; end
                3'd3: begin
                    if (mosi !== held) strobe_viol++;
                    if (++cnt == 2) begin spi_st = 3'd4; last_done = cyc; done_valid = 1; end
                end
                default: spi_st = 3'd0;
            endcase
        end
    end

    task automatic pulse(input logic [15:0] a, input logic [15:0] b);
        a_data = a; b_data = b; upd = 1'b1;
        @(negedge clk);
        upd = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) begin ok = 1; break; end
        end
        check(name, {31'b0, ok}, 32'd1);
    endtask

    task automatic wait_run(input string name, input logic [23:0] w);
        bit ok = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (spi_st == 3'd2 && mosi == w) begin ok = 1; break; end
        end
        check(name, {31'b0, ok}, 32'd1);
    endtask

    task automatic wait_err(input string name);
        bit ok = 0;
        for (int i = 0; i < POR_DELAY + TIMEOUT + 200; i++) begin
            @(negedge clk);
            if (err) begin ok = 1; break; end
        end
        check(name, {31'b0, ok}, 32'd1);
    endtask

    task automatic push_init();
        exp_q.push_back(24'h280001);
        exp_q.push_back(24'h380001);
        exp_q.push_back(24'h300003);
        exp_q.push_back(24'h020000);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_start"}, {31'b0, spi_start}, 32'd0);
        check({tag, "_mosi"},  {8'h0, mosi},       32'd0);
        check({tag, "_init"},  {31'b0, init_done}, 32'd0);
        check({tag, "_err"},   {31'b0, err},       32'd0);
        check({tag, "_busy"},  {31'b0, busy},      32'd1);
    endtask

    initial begin
        int cyc;
        int seen;
        rst_n = 1'b0; upd = 1'b0; a_data = '0; b_data = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");

        // Init sequence and power-on delay
        push_init();
        rst_n = 1'b1;
        cyc = 0;
        while (!spi_start && cyc < POR_DELAY + 50) begin @(negedge clk); cyc++; end
        check("por_delay", cyc, POR_DELAY + 1);
        wait_idle("init_idle");
        check("init_done", {31'b0, init_done}, 32'd1);
        check("init_err", {31'b0, err}, 32'd0);

        // Single update from IDLE, with start latency
        exp_q.push_back(24'h001234);
        exp_q.push_back(24'h11ABCD);
        pulse(16'h1234, 16'hABCD);
        check("upd_lat1", {31'b0, spi_start}, 32'd0);
        @(negedge clk);
        check("upd_lat2", {31'b0, spi_start}, 32'd1);

        // Two requests while the B frame is in flight: only the last is served
        wait_run("b_inflight", 24'h11ABCD);
        exp_q.push_back(24'h000001);
        exp_q.push_back(24'h110002);
        pulse(16'h7777, 16'h8888);
        pulse(16'h0001, 16'h0002);
        wait_idle("pair_idle");
        check("pair_busy", {31'b0, busy}, 32'd0);

        // Master never acks: timeout, pair dropped
        no_ack = 1'b1;
        seen = frames_seen;
        pulse(16'h5A5A, 16'hA5A5);
        wait_err("to_err");
        check("to_start", {31'b0, spi_start}, 32'd0);
        repeat (20) @(negedge clk);
        check("to_busy", {31'b0, busy}, 32'd0);
        check("to_frames", frames_seen, seen);
        no_ack = 1'b0;
        repeat (20) @(negedge clk);
        check("to_noretry", frames_seen, seen);

        // Later updates are still served; error stays sticky
        exp_q.push_back(24'h000F0F);
        exp_q.push_back(24'h11F0F0);
        pulse(16'h0F0F, 16'hF0F0);
        wait_idle("post_to_idle");
        check("err_sticky", {31'b0, err}, 32'd1);

        // Reset during the A frame's run state, update during POR
        exp_q.push_back(24'h00AAAA);
        exp_q.push_back(24'h115555);
        pulse(16'hAAAA, 16'h5555);
        wait_run("a_run", 24'h00AAAA);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        exp_q.delete();
        repeat (3) @(negedge clk);
        push_init();
        exp_q.push_back(24'h000102);
        exp_q.push_back(24'h110304);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        pulse(16'h0102, 16'h0304);
        wait_idle("replay_idle");
        check("replay_init", {31'b0, init_done}, 32'd1);

        // Timeout on the first init frame: updates ignored until reset
        no_ack = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_err("init_to_err");
        check("init_to_done", {31'b0, init_done}, 32'd0);
        no_ack = 1'b0;
        seen = frames_seen;
        pulse(16'h4321, 16'h8765);
        repeat (100) @(negedge clk);
        check("init_to_busy", {31'b0, busy}, 32'd0);
        check("init_to_frames", frames_seen, seen);

        check("strobe_violations", strobe_viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
